// File: rtl/count_monitor_if.sv
// Signal bundle between an upstream 4-bit up/down counter and its monitor.
// The master side drives the counter observation and control inputs.
// The slave side (the monitor) returns the step, wrap, error and alarm status.
interface count_monitor_if #(
  parameter int WRAP_W = 8
);
  logic [3:0]        Count;
  logic              UpOrDown;
  logic              CntClr;
  logic              AlarmClr;
  logic              Step;
  logic              StepUp;
  logic              Wrap;
  logic [WRAP_W-1:0] WrapCount;
  logic              Glitch;
  logic              Mismatch;
  logic              Alarm;
  logic [1:0]        State;

  modport master (
    output Count, UpOrDown, CntClr, AlarmClr,
    input  Step, StepUp, Wrap, WrapCount, Glitch, Mismatch, Alarm, State
  );

  modport slave (
    input  Count, UpOrDown, CntClr, AlarmClr,
    output Step, StepUp, Wrap, WrapCount, Glitch, Mismatch, Alarm, State
  );
endinterface

// File: rtl/count_monitor.sv
// Watches a 4-bit up/down counter and classifies each new sample against the
// previous one as hold, legal step (with wrap detection) or illegal jump.
// It also flags steps that go against the commanded direction.
// Glitches and direction mismatches accumulate in a saturating error counter.
// When that counter reaches ERR_TH, a sticky ALARM state is entered and held
// until AlarmClr. Every output is registered with one cycle of latency.
module count_monitor #(
  parameter int WRAP_W = 8,
  parameter int ERR_TH = 3
) (
  input logic             Clk,
  input logic             reset,
  count_monitor_if.slave  mon
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRACK = 2'b01,
    ALARM = 2'b10
  } state_t;

  localparam logic [3:0] ERR_TH_C = 4'(ERR_TH);

  state_t            state_q, state_d;
  logic [3:0]        prev_q;
  logic [3:0]        delta;
  logic              is_up, is_down;
  logic [3:0]        err_cnt_q, err_cnt_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              step_q, step_d;
  logic              step_up_q, step_up_d;
  logic              wrap_q, wrap_d;
  logic              glitch_q, glitch_d;
  logic              mismatch_q, mismatch_d;
  logic              alarm_q;

  // Modulo-16 difference between the new sample and the previous one.
  // The 4-bit subtraction wraps naturally, so 1 is an up step and 15 is a down step.
  assign delta   = mon.Count - prev_q;
  assign is_up   = (delta == 4'd1);
  assign is_down = (delta == 4'hF);

  // Event classification and wrap counting for the current sample.
  // NOTE: every signal assigned in this block receives a default first, so
  // no path through the branches can leave a value held and infer a latch.
  always_comb begin
    step_d     = 1'b0;
    wrap_d     = 1'b0;
    glitch_d   = 1'b0;
    mismatch_d = 1'b0;
    step_up_d  = step_up_q;
    wrap_cnt_d = wrap_cnt_q;
    if (mon.CntClr) begin
      // A forced clear is a legitimate discontinuity, so it is never flagged as an event.
      wrap_cnt_d = '0;
    end else if (state_q != IDLE) begin
      if (is_up || is_down) begin
        step_d     = 1'b1;
        step_up_d  = is_up;
        mismatch_d = (is_up != mon.UpOrDown);
        wrap_d     = is_up ? (prev_q == 4'hF) : (prev_q == 4'h0);
        if (wrap_d && (wrap_cnt_q != '1)) begin
          wrap_cnt_d = wrap_cnt_q + 1'b1;
        end
      end else if (delta != 4'd0) begin
        glitch_d = 1'b1;
      end
    end
  end

  // Saturating error counter. AlarmClr takes priority over a coincident error.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (mon.AlarmClr) begin
      err_cnt_d = 4'd0;
    end else if ((glitch_d || mismatch_d) && (err_cnt_q < ERR_TH_C)) begin
      err_cnt_d = err_cnt_q + 4'd1;
    end
  end

  // Next-state logic.
  // IDLE only primes PrevCount.
  // TRACK escalates once the error count reaches the threshold.
  // ALARM is sticky until AlarmClr.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = TRACK;
      TRACK:   if (!mon.AlarmClr && (err_cnt_d == ERR_TH_C)) state_d = ALARM;
      ALARM:   if (mon.AlarmClr) state_d = TRACK;
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments, so every flop samples
  // the pre-edge values and evaluation order between blocks cannot matter.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge Clk) begin
    if (reset) begin
      prev_q     <= 4'd0;
      err_cnt_q  <= 4'd0;
      wrap_cnt_q <= '0;
      step_q     <= 1'b0;
      step_up_q  <= 1'b1;
      wrap_q     <= 1'b0;
      glitch_q   <= 1'b0;
      mismatch_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      prev_q     <= mon.Count;
      err_cnt_q  <= err_cnt_d;
      wrap_cnt_q <= wrap_cnt_d;
      step_q     <= step_d;
      step_up_q  <= step_up_d;
      wrap_q     <= wrap_d;
      glitch_q   <= glitch_d;
      mismatch_q <= mismatch_d;
      alarm_q    <= (state_d == ALARM);
    end
  end

  assign mon.Step      = step_q;
  assign mon.StepUp    = step_up_q;
  assign mon.Wrap      = wrap_q;
  assign mon.WrapCount = wrap_cnt_q;
  assign mon.Glitch    = glitch_q;
  assign mon.Mismatch  = mismatch_q;
  assign mon.Alarm     = alarm_q;
  assign mon.State     = state_q;

endmodule
